// File: rtl/iic_master_a16.sv
// Byte-level I2C master: one 16-bit-address register write or repeated-START read per iic_trig.
// SCL/SDA are open-drain enables; every slot is four quarters of CLK_DIV clocks each.
module iic_master_a16 #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  device_id,
    input  logic        iic_trig,
    input  logic        w_r,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    output logic        busy,
    output logic [7:0]  data_out,
    output logic        byte_over,
    output logic        ack_err,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        scl_in,
    input  logic        sda_in
);
    localparam int unsigned CW = 12;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, START, TX_BYTE, TX_ACK, RESTART, RX_BYTE, RX_NACK, STOP
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          wr_q, wr_d;
    logic [7:0]    dev_q, dev_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          samp_q, samp_d;
    logic          busy_q, busy_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          byte_over_q, byte_over_d;
    logic          ack_err_q, ack_err_d;
    logic          scl_oe_q, scl_oe_d;
    logic          sda_oe_q, sda_oe_d;
    logic          slot_end;

    // Line enables {scl_oe, sda_oe} for a given slot type and quarter.
    function automatic logic [1:0] line_drive(input state_e st, input logic [1:0] qt, input logic txb);
        logic scl_lo;
        scl_lo = (qt == 2'd0) || (qt == 2'd3);
        case (st)
            IDLE:    line_drive = 2'b00;
            START:   line_drive = {qt == 2'd3, qt[1]};
            TX_BYTE: line_drive = {scl_lo, ~txb};
            RESTART: line_drive = {scl_lo, qt[1]};
            STOP:    line_drive = {qt == 2'd0, qt != 2'd3};
            default: line_drive = {scl_lo, 1'b0};
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        qtr_d       = qtr_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        wr_d        = wr_q;
        dev_d       = dev_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        samp_d      = samp_q;
        busy_d      = busy_q;
        data_out_d  = data_out_q;
        byte_over_d = 1'b0;
        ack_err_d   = ack_err_q;
        slot_end    = 1'b0;

        // Quarter timebase; a slave holding SCL low in Q1 freezes it.
        if (state_q != IDLE) begin
            if (!(qtr_q == 2'd1 && !scl_in)) begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d    = '0;
                    qtr_d    = qtr_q + 2'd1;
                    slot_end = (qtr_q == 2'd3);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            if (qtr_q == 2'd2 && cnt_q == '0) samp_d = sda_in;
        end

        case (state_q)
            IDLE: if (iic_trig) begin
                dev_d     = device_id;
                wr_d      = w_r;
                addr_d    = addr;
                wdata_d   = data_in;
                busy_d    = 1'b1;
                ack_err_d = 1'b0;
                cnt_d     = '0;
                qtr_d     = 2'd0;
                state_d   = START;
            end
            START: if (slot_end) begin
                shift_d = dev_q;
                bit_d   = 3'd0;
                idx_d   = 2'd0;
                state_d = TX_BYTE;
            end
            TX_BYTE: if (slot_end) begin
                if (bit_q == 3'd7) begin
                    state_d = TX_ACK;
                end else begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = {shift_q[6:0], 1'b0};
                end
            end
            TX_ACK: if (slot_end) begin
                bit_d = 3'd0;
                if (samp_q) begin
                    ack_err_d = 1'b1;
                    state_d   = STOP;
                end else begin
                    case (idx_q)
                        2'd0: begin shift_d = addr_q[15:8]; idx_d = 2'd1; state_d = TX_BYTE; end
                        2'd1: begin shift_d = addr_q[7:0];  idx_d = 2'd2; state_d = TX_BYTE; end
                        2'd2: begin
                            if (wr_q) begin
                                shift_d = wdata_q;
                                idx_d   = 2'd3;
                                state_d = TX_BYTE;
                            end else begin
                                state_d = RESTART;
                            end
                        end
                        default: begin
                            if (wr_q) begin
                                byte_over_d = 1'b1;
                                state_d     = STOP;
                            end else begin
                                state_d = RX_BYTE;
                            end
                        end
                    endcase
                end
            end
            RESTART: if (slot_end) begin
                shift_d = dev_q | 8'h01;
                idx_d   = 2'd3;
                bit_d   = 3'd0;
                state_d = TX_BYTE;
            end
            RX_BYTE: if (slot_end) begin
                shift_d = {shift_q[6:0], samp_q};
                if (bit_q == 3'd7) state_d = RX_NACK;
                else               bit_d   = bit_q + 3'd1;
            end
            RX_NACK: if (slot_end) begin
                byte_over_d = 1'b1;
                data_out_d  = shift_q;
                state_d     = STOP;
            end
            STOP: if (slot_end) begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Pad enables follow the upcoming slot/quarter so they change exactly on quarter boundaries.
        {scl_oe_d, sda_oe_d} = line_drive(state_d, qtr_d, shift_d[7]);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            qtr_q       <= 2'd0;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            idx_q       <= 2'd0;
            shift_q     <= 8'h00;
            wr_q        <= 1'b0;
            dev_q       <= 8'h00;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            samp_q      <= 1'b1;
            busy_q      <= 1'b0;
            data_out_q  <= 8'h00;
            byte_over_q <= 1'b0;
            ack_err_q   <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            qtr_q       <= qtr_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            wr_q        <= wr_d;
            dev_q       <= dev_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            samp_q      <= samp_d;
            busy_q      <= busy_d;
            data_out_q  <= data_out_d;
            byte_over_q <= byte_over_d;
            ack_err_q   <= ack_err_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
        end
    end

    assign busy      = busy_q;
    assign data_out  = data_out_q;
    assign byte_over = byte_over_q;
    assign ack_err   = ack_err_q;
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_iic_master_a16.sv
// Directed bench for iic_master_a16: bus decoder plus a register-slave model on the open-drain lines.
module tb_iic_master_a16;
    localparam int unsigned CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  device_id;
    logic        iic_trig;
    logic        w_r;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        busy;
    logic [7:0]  data_out;
    logic        byte_over;
    logic        ack_err;
    logic        scl_oe;
    logic        sda_oe;
    logic        scl_in;
    logic        sda_in;

    // Slave / bus-monitor state
    logic        slv_sda  = 1'b0;
    logic        pend     = 1'b0;
    int          hold_cnt = 0;
    logic        scl_prev = 1'b1;
    logic        sda_prev = 1'b1;
    logic        chg      = 1'b1;
    logic        bits_a [0:1023];
    int          nbits    = 0;
    int          bo_total = 0;

    // Stimulus-side configuration of the slave
    int          tx_base    = 0;
    logic        rd_mode    = 1'b0;
    logic [7:0]  rd_byte    = 8'h00;
    int          nack_g     = 99;
    logic        stretch_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign scl_in = ~(scl_oe | pend | (hold_cnt != 0));
    assign sda_in = ~(sda_oe | slv_sda);

    iic_master_a16 #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .device_id (device_id),
        .iic_trig  (iic_trig),
        .w_r       (w_r),
        .addr      (addr),
        .data_in   (data_in),
        .busy      (busy),
        .data_out  (data_out),
        .byte_over (byte_over),
        .ack_err   (ack_err),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .scl_in    (scl_in),
        .sda_in    (sda_in)
    );

    // Data bits are SCL pulses with SDA stable while high; START/RESTART/STOP are excluded.
    always @(negedge clk) begin
        int m;
        int b;
        if (byte_over) bo_total <= bo_total + 1;
        if (hold_cnt != 0) hold_cnt <= hold_cnt - 1;
        else if (pend && !scl_oe) begin
            pend     <= 1'b0;
            hold_cnt <= 50;
        end
        if (scl_in && !scl_prev) chg <= 1'b0;
        else if (scl_in && scl_prev && (sda_in != sda_prev)) chg <= 1'b1;
        if (!scl_in && scl_prev && !chg) begin
            bits_a[nbits] <= sda_prev;
            nbits <= nbits + 1;
            m = nbits + 1 - tx_base;
            b = m % 9;
            if (stretch_en && m == 12) pend <= 1'b1;
            if (rd_mode && (m / 9) == 4) slv_sda <= (b < 8) ? ~rd_byte[7 - b] : 1'b0;
            else if (b == 8)             slv_sda <= ((m / 9) != nack_g);
            else                         slv_sda <= 1'b0;
        end
        scl_prev <= scl_in;
        sda_prev <= sda_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Byte g of the current transaction as {data[7:0], ack_bit}.
    function automatic logic [8:0] grp(input int g);
        logic [8:0] r;
        for (int i = 0; i < 9; i++) r[8 - i] = bits_a[tx_base + 9 * g + i];
        return r;
    endfunction

    task automatic start_txn(input logic wr, input logic [15:0] a, input logic [7:0] d);
        tx_base  = nbits;
        w_r      = wr;
        addr     = a;
        data_in  = d;
        iic_trig = 1'b1;
        @(negedge clk);
        iic_trig = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 20000 && busy !== 1'b0; i++) begin
            n++;
            @(negedge clk);
        end
        chk("busy_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int bo0;
        rstn      = 1'b0;
        iic_trig  = 1'b0;
        w_r       = 1'b1;
        addr      = 16'h0000;
        data_in   = 8'h00;
        device_id = 8'hB2;
        repeat (5) @(negedge clk);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_byte_over", 32'(byte_over), 32'd0);
        chk("rst_ack_err",   32'(ack_err),   32'd0);
        chk("rst_data_out",  32'(data_out),  32'h00);
        chk("rst_scl_oe",    32'(scl_oe),    32'd0);
        chk("rst_sda_oe",    32'(sda_oe),    32'd0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // Register write 0x0003 <= 0x5A
        bo0 = bo_total;
        start_txn(1'b1, 16'h0003, 8'h5A);
        chk("wr_busy_rise", 32'(busy), 32'd1);
        wait_idle(n);
        chk("wr_busy_cycles", 32'(n), 32'd608);
        chk("wr_nbits",       32'(nbits - tx_base), 32'd36);
        chk("wr_byte0",       32'(grp(0)), 32'({8'hB2, 1'b0}));
        chk("wr_byte1",       32'(grp(1)), 32'({8'h00, 1'b0}));
        chk("wr_byte2",       32'(grp(2)), 32'({8'h03, 1'b0}));
        chk("wr_byte3",       32'(grp(3)), 32'({8'h5A, 1'b0}));
        chk("wr_byte_over",   32'(bo_total - bo0), 32'd1);
        chk("wr_ack_err",     32'(ack_err), 32'd0);
        repeat (3) @(negedge clk);

        // Random read of 0x0003, slave returns 0x5A
        rd_mode = 1'b1;
        rd_byte = 8'h5A;
        bo0     = bo_total;
        start_txn(1'b0, 16'h0003, 8'h00);
        wait_idle(n);
        chk("rd_busy_cycles", 32'(n), 32'd768);
        chk("rd_nbits",       32'(nbits - tx_base), 32'd45);
        chk("rd_byte0",       32'(grp(0)), 32'({8'hB2, 1'b0}));
        chk("rd_byte1",       32'(grp(1)), 32'({8'h00, 1'b0}));
        chk("rd_byte2",       32'(grp(2)), 32'({8'h03, 1'b0}));
        chk("rd_byte3",       32'(grp(3)), 32'({8'hB3, 1'b0}));
        chk("rd_data_nack",   32'(grp(4)), 32'({8'h5A, 1'b1}));
        chk("rd_data_out",    32'(data_out), 32'h5A);
        chk("rd_byte_over",   32'(bo_total - bo0), 32'd1);
        rd_mode = 1'b0;
        repeat (3) @(negedge clk);

        // Slave NACKs addr_lo
        nack_g = 2;
        bo0    = bo_total;
        start_txn(1'b1, 16'h0003, 8'h77);
        wait_idle(n);
        chk("nack_ack_err",     32'(ack_err), 32'd1);
        chk("nack_nbits",       32'(nbits - tx_base), 32'd27);
        chk("nack_addr_lo",     32'(grp(2)), 32'({8'h03, 1'b1}));
        chk("nack_busy_cycles", 32'(n), 32'd464);
        chk("nack_byte_over",   32'(bo_total - bo0), 32'd0);
        chk("nack_data_out",    32'(data_out), 32'h5A);
        nack_g = 99;
        repeat (3) @(negedge clk);

        // Clock stretching: 50 cycles during bit 3 of addr_hi
        stretch_en = 1'b1;
        bo0        = bo_total;
        start_txn(1'b1, 16'h0003, 8'h5A);
        chk("trig_clears_ack_err", 32'(ack_err), 32'd0);
        wait_idle(n);
        chk("str_busy_cycles", 32'(n), 32'd658);
        chk("str_nbits",       32'(nbits - tx_base), 32'd36);
        chk("str_byte1",       32'(grp(1)), 32'({8'h00, 1'b0}));
        chk("str_byte3",       32'(grp(3)), 32'({8'h5A, 1'b0}));
        chk("str_byte_over",   32'(bo_total - bo0), 32'd1);
        stretch_en = 1'b0;
        repeat (3) @(negedge clk);

        // Mid-transaction trig ignored, then back-to-back request on the busy-falling cycle
        start_txn(1'b1, 16'h1234, 8'hC3);
        repeat (100) @(negedge clk);
        w_r      = 1'b0;
        iic_trig = 1'b1;
        @(negedge clk);
        iic_trig = 1'b0;
        chk("mid_busy_held", 32'(busy), 32'd1);
        wait_idle(n);
        chk("mid_busy_cycles", 32'(101 + n), 32'd608);
        chk("mid_byte1",       32'(grp(1)), 32'({8'h12, 1'b0}));
        chk("mid_byte3",       32'(grp(3)), 32'({8'hC3, 1'b0}));
        start_txn(1'b1, 16'h0003, 8'h5A);
        chk("b2b_busy_rise", 32'(busy), 32'd1);
        wait_idle(n);
        chk("b2b_busy_cycles", 32'(n), 32'd608);
        chk("b2b_byte0",       32'(grp(0)), 32'({8'hB2, 1'b0}));
        repeat (3) @(negedge clk);

        // Reset in the middle of RX_BYTE
        rd_mode = 1'b1;
        rd_byte = 8'hA5;
        start_txn(1'b0, 16'h0003, 8'h00);
        for (int i = 0; i < 2000 && (nbits - tx_base) < 38; i++) @(negedge clk);
        chk("rx_reached", 32'(nbits - tx_base), 32'd38);
        rstn = 1'b0;
        @(negedge clk);
        chk("arst_busy",      32'(busy),      32'd0);
        chk("arst_scl_oe",    32'(scl_oe),    32'd0);
        chk("arst_sda_oe",    32'(sda_oe),    32'd0);
        chk("arst_data_out",  32'(data_out),  32'h00);
        chk("arst_byte_over", 32'(byte_over), 32'd0);
        rd_mode = 1'b0;
        rstn    = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
